// File: rtl/ws281x_chain_driver_if.sv
// Frame-buffer pull port, control/status and serial data pin of the WS281x chain driver.
// master = driver side, slave = frame buffer / controller side.
interface ws281x_chain_driver_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned PIX_W  = 24
);
  logic              start;
  logic              data_request;
  logic [ADDR_W-1:0] address;
  logic [PIX_W-1:0]  pixel_in;
  logic [7:0]        brightness;
  logic              busy;
  logic              frame_done;
  logic              DO;

  modport master (
    input  start, pixel_in, brightness,
    output data_request, address, busy, frame_done, DO
  );

  modport slave (
    output start, pixel_in, brightness,
    input  data_request, address, busy, frame_done, DO
  );
endinterface

// File: rtl/ws281x_chain_driver.sv
// Parametrised WS281x chain driver: pulls pixels from a frame buffer and streams them gap-free.
// Optional global brightness scaling is enabled with `define WS281X_BRIGHTNESS_EN.
module ws281x_chain_driver #(
  parameter int unsigned NUM_LEDS     = 49,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned SYSTEM_CLOCK = 64_000_000,
  parameter int unsigned BIT_RATE     = 800_000,
  parameter int unsigned T0H_NS       = 350,
  parameter int unsigned T1H_NS       = 700,
  parameter int unsigned RESET_US     = 80,
  parameter int unsigned AUTO_REFRESH = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  ws281x_chain_driver_if.master bus
);

  localparam int unsigned PIX_W        = CHANNELS * 8;
  localparam int unsigned ADDR_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned BIT_CYCLES   = SYSTEM_CLOCK / BIT_RATE;
  localparam longint unsigned T0H_PROD = 64'(SYSTEM_CLOCK) * 64'(T0H_NS);
  localparam longint unsigned T1H_PROD = 64'(SYSTEM_CLOCK) * 64'(T1H_NS);
  localparam int unsigned T0H_CYCLES   = 32'(T0H_PROD / 64'd1_000_000_000);
  localparam int unsigned T1H_CYCLES   = 32'(T1H_PROD / 64'd1_000_000_000);
  localparam int unsigned RESET_CYCLES = (SYSTEM_CLOCK / 1_000_000) * RESET_US;
  localparam int unsigned BC_W         = ($clog2(BIT_CYCLES) > 0) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BI_W         = $clog2(PIX_W);
  localparam int unsigned LC_W         = ($clog2(RESET_CYCLES + 1) > 0) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0]   T0H_B     = BC_W'(T0H_CYCLES);
  localparam logic [BC_W-1:0]   T1H_B     = BC_W'(T1H_CYCLES);
  localparam logic [BI_W-1:0]   PIX_LAST  = BI_W'(PIX_W - 1);
  localparam logic [LC_W-1:0]   LATCH_END = LC_W'(RESET_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_LEDS - 1);

  // Reject timing/pixel configurations that cannot produce valid WS281x waveforms.
  if (T1H_CYCLES >= BIT_CYCLES) begin : g_chk_t1h
    $error("ws281x_chain_driver: T1H_CYCLES must be less than BIT_CYCLES");
  end
  if (T0H_CYCLES == 0) begin : g_chk_t0h_zero
    $error("ws281x_chain_driver: T0H_CYCLES must be non-zero");
  end
  if (T0H_CYCLES >= T1H_CYCLES) begin : g_chk_t0h_t1h
    $error("ws281x_chain_driver: T0H_CYCLES must be less than T1H_CYCLES");
  end
  if (CHANNELS != 3 && CHANNELS != 4) begin : g_chk_channels
    $error("ws281x_chain_driver: CHANNELS must be 3 or 4");
  end
  if (NUM_LEDS < 1) begin : g_chk_num_leds
    $error("ws281x_chain_driver: NUM_LEDS must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } state_t;

  state_t            r_state,        w_state_nxt;
  logic [BC_W-1:0]   r_bit_cnt,      w_bit_cnt_nxt;
  logic [BI_W-1:0]   r_bit_idx,      w_bit_idx_nxt;
  logic [LC_W-1:0]   r_latch_cnt,    w_latch_cnt_nxt;
  logic [PIX_W-1:0]  r_shift,        w_shift_nxt;
  logic [PIX_W-1:0]  r_hold,         w_hold_nxt;
  logic              r_have_next,    w_have_next_nxt;
  logic [ADDR_W-1:0] r_address,      w_address_nxt;
  logic              r_data_request, w_data_request_nxt;
  logic              r_busy,         w_busy_nxt;
  logic              r_frame_done,   w_frame_done_nxt;
  logic              r_do,           w_do_nxt;

  logic [PIX_W-1:0]  w_pix_scaled;
  logic [BC_W-1:0]   w_high_cycles;
  logic              w_bit_last;
  logic              w_pix_last;

`ifdef WS281X_BRIGHTNESS_EN
  // Per-channel (ch * brightness + 255) >> 8 so that 255 is identity and 0 blanks.
  always_comb begin
    logic [15:0] prod;
    w_pix_scaled = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      prod = 16'(bus.pixel_in[c*8 +: 8]) * 16'(bus.brightness) + 16'd255;
      w_pix_scaled[c*8 +: 8] = prod[15:8];
    end
  end
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^bus.brightness;
  assign w_pix_scaled        = bus.pixel_in;
`endif

  assign w_bit_last    = (r_bit_cnt == BIT_LAST);
  assign w_pix_last    = (r_bit_idx == PIX_LAST);
  assign w_high_cycles = r_shift[PIX_W-1] ? T1H_B : T0H_B;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= '0;
      r_bit_idx      <= '0;
      r_latch_cnt    <= '0;
      r_shift        <= '0;
      r_hold         <= '0;
      r_have_next    <= 1'b0;
      r_address      <= '0;
      r_data_request <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_do           <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_bit_idx      <= w_bit_idx_nxt;
      r_latch_cnt    <= w_latch_cnt_nxt;
      r_shift        <= w_shift_nxt;
      r_hold         <= w_hold_nxt;
      r_have_next    <= w_have_next_nxt;
      r_address      <= w_address_nxt;
      r_data_request <= w_data_request_nxt;
      r_busy         <= w_busy_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_do           <= w_do_nxt;
    end
  end

  // Next-state and next-output logic; DO is registered so it trails the bit counter by one cycle.
  always_comb begin
    w_state_nxt        = r_state;
    w_bit_cnt_nxt      = r_bit_cnt;
    w_bit_idx_nxt      = r_bit_idx;
    w_latch_cnt_nxt    = r_latch_cnt;
    w_shift_nxt        = r_shift;
    w_hold_nxt         = r_hold;
    w_have_next_nxt    = r_have_next;
    w_address_nxt      = r_address;
    w_data_request_nxt = 1'b0;
    w_busy_nxt         = r_busy;
    w_frame_done_nxt   = 1'b0;
    w_do_nxt           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_address_nxt = '0;
        if (bus.start || (AUTO_REFRESH != 0)) begin
          w_state_nxt        = ST_FETCH;
          w_busy_nxt         = 1'b1;
          w_data_request_nxt = 1'b1;
        end
      end

      ST_FETCH: begin
        w_shift_nxt     = w_pix_scaled;
        w_bit_cnt_nxt   = '0;
        w_bit_idx_nxt   = '0;
        w_have_next_nxt = 1'b0;
        w_state_nxt     = ST_SEND;
      end

      ST_SEND: begin
        w_do_nxt = (r_bit_cnt < w_high_cycles);

        // Prefetched pixel arrives the cycle after its request.
        if (r_data_request) begin
          w_hold_nxt      = w_pix_scaled;
          w_have_next_nxt = 1'b1;
        end

        if ((r_bit_cnt == '0) && w_pix_last && (r_address < ADDR_LAST)) begin
          w_data_request_nxt = 1'b1;
          w_address_nxt      = r_address + ADDR_W'(1);
        end

        if (w_bit_last) begin
          w_bit_cnt_nxt = '0;
          if (w_pix_last) begin
            w_bit_idx_nxt = '0;
            if (r_have_next) begin
              w_shift_nxt     = r_hold;
              w_have_next_nxt = 1'b0;
            end else begin
              w_latch_cnt_nxt = '0;
              w_state_nxt     = ST_LATCH;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + BI_W'(1);
            w_shift_nxt   = {r_shift[PIX_W-2:0], 1'b0};
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
        end
      end

      ST_LATCH: begin
        if (r_latch_cnt == LATCH_END) begin
          w_frame_done_nxt = 1'b1;
          w_busy_nxt       = 1'b0;
          w_address_nxt    = '0;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_latch_cnt_nxt = r_latch_cnt + LC_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.data_request = r_data_request;
  assign bus.address      = r_address;
  assign bus.busy         = r_busy;
  assign bus.frame_done   = r_frame_done;
  assign bus.DO           = r_do;

endmodule

// File: tb/tb_ws281x_chain_driver.sv
// Directed bench for ws281x_chain_driver: four instances cover timing/prefetch, GRBW,
// auto-refresh and single-LED/brightness; each captured bit window is decoded by high time.
module tb_ws281x_chain_driver;

  localparam int BITC = 10;
  localparam int T0C  = 3;
  localparam int T1C  = 6;

  logic clk;
  logic rst_n;
  logic rst_n_c;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  ws281x_chain_driver_if #(.ADDR_W(2), .PIX_W(24)) if_a ();
  ws281x_chain_driver_if #(.ADDR_W(1), .PIX_W(32)) if_b ();
  ws281x_chain_driver_if #(.ADDR_W(1), .PIX_W(24)) if_c ();
  ws281x_chain_driver_if #(.ADDR_W(1), .PIX_W(24)) if_d ();

  ws281x_chain_driver #(
    .NUM_LEDS(3), .CHANNELS(3), .SYSTEM_CLOCK(8_000_000), .BIT_RATE(800_000),
    .T0H_NS(375), .T1H_NS(750), .RESET_US(5), .AUTO_REFRESH(0)
  ) u_a (.clk(clk), .reset(rst_n), .bus(if_a));

  ws281x_chain_driver #(
    .NUM_LEDS(2), .CHANNELS(4), .SYSTEM_CLOCK(8_000_000), .BIT_RATE(800_000),
    .T0H_NS(375), .T1H_NS(750), .RESET_US(5), .AUTO_REFRESH(0)
  ) u_b (.clk(clk), .reset(rst_n), .bus(if_b));

  ws281x_chain_driver #(
    .NUM_LEDS(2), .CHANNELS(3), .SYSTEM_CLOCK(8_000_000), .BIT_RATE(800_000),
    .T0H_NS(375), .T1H_NS(750), .RESET_US(5), .AUTO_REFRESH(1)
  ) u_c (.clk(clk), .reset(rst_n_c), .bus(if_c));

  ws281x_chain_driver #(
    .NUM_LEDS(1), .CHANNELS(3), .SYSTEM_CLOCK(8_000_000), .BIT_RATE(800_000),
    .T0H_NS(375), .T1H_NS(750), .RESET_US(5), .AUTO_REFRESH(0)
  ) u_d (.clk(clk), .reset(rst_n), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer contents, returned combinationally for the presented address.
  always_comb begin
    case (if_a.address)
      2'd0:    if_a.pixel_in = 24'hFF0000;
      2'd1:    if_a.pixel_in = 24'hA50F3C;
      default: if_a.pixel_in = 24'h817E42;
    endcase
    if_b.pixel_in = 32'h8000_0001;
    if_c.pixel_in = (if_c.address == 1'b0) ? 24'h123456 : 24'hF00F55;
    if_d.pixel_in = 24'hFF8001;
  end

  int         sel;
  logic       sel_do, sel_fd, sel_req, sel_busy;
  logic [7:0] sel_addr;

  always_comb begin
    case (sel)
      0: begin
        sel_do = if_a.DO; sel_fd = if_a.frame_done; sel_req = if_a.data_request;
        sel_busy = if_a.busy; sel_addr = 8'(if_a.address);
      end
      1: begin
        sel_do = if_b.DO; sel_fd = if_b.frame_done; sel_req = if_b.data_request;
        sel_busy = if_b.busy; sel_addr = 8'(if_b.address);
      end
      2: begin
        sel_do = if_c.DO; sel_fd = if_c.frame_done; sel_req = if_c.data_request;
        sel_busy = if_c.busy; sel_addr = 8'(if_c.address);
      end
      default: begin
        sel_do = if_d.DO; sel_fd = if_d.frame_done; sel_req = if_d.data_request;
        sel_busy = if_d.busy; sel_addr = 8'(if_d.address);
      end
    endcase
  end

  // Request log of the selected instance.
  int req_n = 0;
  int req_addr [16];
  int req_cyc  [16];
  always @(negedge clk) begin
    if (sel_req === 1'b1) begin
      req_addr[req_n % 16] = int'(sel_addr);
      req_cyc[req_n % 16]  = cyc;
      req_n = req_n + 1;
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the first DO rise, decodes nbits fixed-length bit windows, then counts latch-low cycles.
  task automatic capture(input int nbits, output logic [95:0] bits, output int serr,
                         output int rise, output int llow);
    int l;
    bits = '0;
    serr = 0;
    rise = -1;
    llow = -1;
    for (int i = 0; i < 200 && sel_do !== 1'b1; i++) @(negedge clk);
    if (sel_do !== 1'b1) begin
      serr = 1000;
      return;
    end
    rise = cyc;
    for (int b = 0; b < nbits; b++) begin
      int  h;
      bit  seen_low;
      h = 0;
      seen_low = 1'b0;
      for (int c = 0; c < BITC; c++) begin
        if (sel_do === 1'b1) begin
          if (seen_low) serr++;
          h++;
        end else begin
          seen_low = 1'b1;
        end
        @(negedge clk);
      end
      if (h == T1C)      bits = {bits[94:0], 1'b1};
      else if (h == T0C) bits = {bits[94:0], 1'b0};
      else               serr++;
    end
    l = 0;
    while (sel_fd !== 1'b1 && l < 200) begin
      if (sel_do !== 1'b0) serr++;
      l++;
      @(negedge clk);
    end
    llow = l;
  endtask

  initial begin
    logic [95:0] bits;
    logic [23:0] exp_d;
    int serr, rise, llow, r0, x, fd_cyc;

    sel = 0;
    rst_n = 1'b0;
    rst_n_c = 1'b0;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0; if_d.start = 1'b0;
    if_a.brightness = 8'd255; if_b.brightness = 8'd255; if_c.brightness = 8'd255;
    if_d.brightness = 8'd128;
    repeat (3) @(negedge clk);

    check("rst_do",   96'(if_a.DO), 96'(0));
    check("rst_busy", 96'(if_a.busy), 96'(0));
    check("rst_req",  96'(if_a.data_request), 96'(0));
    check("rst_addr", 96'(if_a.address), 96'(0));
    check("rst_fd",   96'(if_a.frame_done), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 96'(if_a.busy), 96'(0));

    // A: GRB timing, prefetch handshake and gap-free pixel boundaries.
    sel = 0;
    r0 = req_n;
    x = cyc;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    check("a_busy_start", 96'(if_a.busy), 96'(1));
    check("a_req_start",  96'({if_a.data_request, 6'(if_a.address)}), 96'({1'b1, 6'd0}));
    capture(72, bits, serr, rise, llow);
    check("a_bits",      bits[71:0], 96'(72'hFF0000_A50F3C_817E42));
    check("a_shape",     96'(serr), 96'(0));
    check("a_rise_lat",  96'(rise - x), 96'(3));
    check("a_latch_low", 96'(llow), 96'(40));
    check("a_busy_fd",   96'(if_a.busy), 96'(0));
    check("a_req_count", 96'(req_n - r0), 96'(3));
    check("a_req_addrs", 96'({8'(req_addr[r0 % 16]), 8'(req_addr[(r0 + 1) % 16]),
                              8'(req_addr[(r0 + 2) % 16])}), 96'(24'h00_01_02));
    check("a_req_to_rise", 96'(rise - req_cyc[r0 % 16]), 96'(2));

    // A: asynchronous reset while pixel 1 is on the wire.
    repeat (5) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (300) @(negedge clk);
    for (int i = 0; i < 20 && if_a.DO !== 1'b1; i++) @(negedge clk);
    check("a_pre_rst_do", 96'(if_a.DO), 96'(1));
    #2 rst_n = 1'b0;
    #1;
    check("a_midrst_do",   96'(if_a.DO), 96'(0));
    check("a_midrst_busy", 96'(if_a.busy), 96'(0));
    check("a_midrst_addr", 96'(if_a.address), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A: restart after reset begins again at address 0.
    r0 = req_n;
    x = cyc;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    capture(72, bits, serr, rise, llow);
    check("a2_bits",       bits[71:0], 96'(72'hFF0000_A50F3C_817E42));
    check("a2_shape",      96'(serr), 96'(0));
    check("a2_req_to_rise", 96'(rise - req_cyc[r0 % 16]), 96'(2));
    check("a2_first_addr", 96'(req_addr[r0 % 16]), 96'(0));

    // A: start pulses mid-frame and during latch are ignored.
    repeat (5) @(negedge clk);
    r0 = req_n;
    x = cyc;
    fd_cyc = -1;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if_a.start = (i == 100 || i == 740);
      @(negedge clk);
      if (if_a.frame_done === 1'b1) begin
        fd_cyc = cyc;
        break;
      end
    end
    if_a.start = 1'b0;
    check("a_fd_time", 96'(fd_cyc - x), 96'(763));
    repeat (20) @(negedge clk);
    check("a_ign_req_count", 96'(req_n - r0), 96'(3));
    check("a_ign_busy",      96'(if_a.busy), 96'(0));

    // B: GRBW, two pixels of 0x80000001.
    sel = 1;
    @(negedge clk);
    r0 = req_n;
    if_b.start = 1'b1;
    @(negedge clk);
    if_b.start = 1'b0;
    capture(64, bits, serr, rise, llow);
    check("b_bits",      bits[63:0], 96'(64'h8000_0001_8000_0001));
    check("b_shape",     96'(serr), 96'(0));
    check("b_latch_low", 96'(llow), 96'(40));
    check("b_req_count", 96'(req_n - r0), 96'(2));
    check("b_req_addrs", 96'({8'(req_addr[r0 % 16]), 8'(req_addr[(r0 + 1) % 16])}),
          96'(16'h00_01));

    // D: single LED (no prefetch) with brightness 128.
    sel = 3;
    @(negedge clk);
    r0 = req_n;
`ifdef WS281X_BRIGHTNESS_EN
    exp_d = 24'h804001;
`else
    exp_d = 24'hFF8001;
`endif
    if_d.start = 1'b1;
    @(negedge clk);
    if_d.start = 1'b0;
    capture(24, bits, serr, rise, llow);
    check("d_bits",      bits[23:0], 96'(exp_d));
    check("d_shape",     96'(serr), 96'(0));
    check("d_latch_low", 96'(llow), 96'(40));
    check("d_req_count", 96'(req_n - r0), 96'(1));

    // C: auto refresh, three back-to-back frames.
    sel = 2;
    @(negedge clk);
    rst_n_c = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture(48, bits, serr, rise, llow);
      check($sformatf("c_bits_f%0d", f), bits[47:0], 96'(48'h123456_F00F55));
      check($sformatf("c_shape_f%0d", f), 96'(serr), 96'(0));
      check($sformatf("c_latch_f%0d", f), 96'(llow), 96'(40));
      @(negedge clk);
      check($sformatf("c_rereq_f%0d", f), 96'({sel_req, sel_addr}), 96'({1'b1, 8'd0}));
    end
    rst_n_c = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
